miller_frame_rx: RTL

MILLER_FRAME_RX -- requirements
Module: miller_frame_rx

---
 rtl/miller_frame_rx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/miller_frame_rx.sv
// Modified-Miller (ISO 14443-A, 106 kbit/s) frame receiver: pause detection, ETU phase
// tracking with drift realignment, symbol decode, and SOF/EOF/error framing.
//
// state | meaning
// IDLE  | waiting for a pause start (SOF)
// RX    | frame in progress, ETU phase counter running
module miller_frame_rx #(
   parameter int ETU_CLKS  = 32,
   parameter int Z_WIN     = 4,
   parameter int X_LO      = 12,
   parameter int X_HI      = 20,
   parameter int PAUSE_MAX = 16
) (
   input  logic       clk,
   input  logic       in_PoR,
   input  logic       in_data,
   output logic       out_bit,
   output logic       out_bit_valid,
   output logic       out_sof,
   output logic       out_eof,
   output logic       out_err,
   output logic       out_busy,
   output logic [7:0] out_nbits
);

   localparam int PH_W  = $clog2(ETU_CLKS);
   localparam int LOW_W = $clog2(PAUSE_MAX + 1);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(ETU_CLKS - 1);
   localparam logic [PH_W-1:0]  PH_ZWIN = PH_W'(Z_WIN);
   localparam logic [PH_W-1:0]  PH_XLO  = PH_W'(X_LO);
   localparam logic [PH_W-1:0]  PH_XHI  = PH_W'(X_HI);
   localparam logic [PH_W-1:0]  PH_XRE  = PH_W'((X_LO + X_HI) / 2 + 1);
   localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(PAUSE_MAX);

   typedef enum logic {S_IDLE, S_RX} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic              seen_q, seen_d, symx_q, symx_d, err_q, err_d;
   logic              sof_q, sof_d, prev_q, prev_d;
   logic              bit_d, valid_d, sofo_d, eof_d, erro_d;
   logic [7:0]        nbits_d;
   logic              sync1, sync2, sync3;
   logic [2:0]        arm_q;
   logic [LOW_W-1:0]  low_cnt;
   logic              pause_start, low_ovf, in_z, in_x, fail;

   // arm_q keeps the preset synchronizer values from looking like a falling edge after reset
   always_ff @(posedge clk or negedge in_PoR) begin
      if (!in_PoR) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         sync3   <= 1'b1;
         arm_q   <= '0;
         low_cnt <= '0;
      end else begin
         sync1 <= in_data;
         sync2 <= sync1;
         sync3 <= sync2;
         arm_q <= {arm_q[1:0], 1'b1};
         if (sync2)
            low_cnt <= '0;
         else if (low_cnt != LOW_MAX)
            low_cnt <= low_cnt + LOW_W'(1);
      end
   end

   assign pause_start = arm_q[2] & sync3 & ~sync2;
   assign low_ovf     = ~sync2 & (low_cnt == LOW_MAX);
   assign in_z        = (ph_q <= PH_ZWIN);
   assign in_x        = (ph_q >= PH_XLO) && (ph_q <= PH_XHI);

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      seen_d  = seen_q;
      symx_d  = symx_q;
      err_d   = err_q;
      sof_d   = sof_q;
      prev_d  = prev_q;
      bit_d   = 1'b0;
      valid_d = 1'b0;
      sofo_d  = 1'b0;
      eof_d   = 1'b0;
      erro_d  = 1'b0;
      nbits_d = out_nbits;
      fail    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ph_d = '0;
            if (pause_start) begin
               state_d = S_RX;
               ph_d    = PH_W'(1);
               seen_d  = 1'b1;
               symx_d  = 1'b0;
               err_d   = 1'b0;
               sof_d   = 1'b1;
               prev_d  = 1'b0;
            end
         end
         S_RX: begin
            if (ph_q != PH_LAST) begin
               ph_d = ph_q + PH_W'(1);
               if (low_ovf)
                  err_d = 1'b1;
               if (pause_start) begin
                  if (seen_q)
                     err_d = 1'b1;
                  else if (in_z) begin
                     seen_d = 1'b1;
                     symx_d = 1'b0;
                     ph_d   = PH_W'(1);
                  end else if (in_x) begin
                     seen_d = 1'b1;
                     symx_d = 1'b1;
                     ph_d   = PH_XRE;
                  end else
                     err_d = 1'b1;
               end
            end else begin
               // ETU boundary: a pause landing here belongs to the next ETU and is out of window
               ph_d   = '0;
               seen_d = 1'b0;
               sof_d  = 1'b0;
               err_d  = pause_start;
               fail   = err_q | low_ovf | (seen_q & ~symx_q & prev_q);
               if (fail) begin
                  erro_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (sof_q) begin
                  sofo_d  = 1'b1;
                  nbits_d = '0;
                  prev_d  = 1'b0;
               end else if (seen_q | prev_q) begin
                  valid_d = 1'b1;
                  bit_d   = seen_q & symx_q;
                  prev_d  = seen_q & symx_q;
                  if (out_nbits != 8'hFF)
                     nbits_d = out_nbits + 8'd1;
               end else begin
                  eof_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge in_PoR) begin
      if (!in_PoR) begin
         state_q       <= S_IDLE;
         ph_q          <= '0;
         seen_q        <= 1'b0;
         symx_q        <= 1'b0;
         err_q         <= 1'b0;
         sof_q         <= 1'b0;
         prev_q        <= 1'b0;
         out_bit       <= 1'b0;
         out_bit_valid <= 1'b0;
         out_sof       <= 1'b0;
         out_eof       <= 1'b0;
         out_err       <= 1'b0;
         out_nbits     <= '0;
      end else begin
         state_q       <= state_d;
         ph_q          <= ph_d;
         seen_q        <= seen_d;
         symx_q        <= symx_d;
         err_q         <= err_d;
         sof_q         <= sof_d;
         prev_q        <= prev_d;
         out_bit       <= bit_d;
         out_bit_valid <= valid_d;
         out_sof       <= sofo_d;
         out_eof       <= eof_d;
         out_err       <= erro_d;
         out_nbits     <= nbits_d;
      end
   end

   assign out_busy = (state_q == S_RX);

endmodule
